// File: rtl/gate_pkg.sv
// Shared definitions for the two-input gate bank: gate identifiers,
// reference truth tables (bit k = output for {a,b}=k) and the sweep FSM states.
package gate_pkg;

   localparam logic [2:0] GATE_AND     = 3'd0;
   localparam logic [2:0] GATE_OR      = 3'd1;
   localparam logic [2:0] GATE_NAND    = 3'd2;
   localparam logic [2:0] GATE_NOTB    = 3'd3;
   localparam logic [2:0] GATE_NOR     = 3'd4;
   localparam logic [2:0] GATE_XOR     = 3'd5;
   localparam logic [2:0] GATE_XNOR    = 3'd6;
   localparam logic [2:0] GATE_UNKNOWN = 3'd7;

   localparam logic [3:0] TT_AND  = 4'b1000;
   localparam logic [3:0] TT_OR   = 4'b1110;
   localparam logic [3:0] TT_NAND = 4'b0111;
   localparam logic [3:0] TT_NOTB = 4'b0101;
   localparam logic [3:0] TT_NOR  = 4'b0001;
   localparam logic [3:0] TT_XOR  = 4'b0110;
   localparam logic [3:0] TT_XNOR = 4'b1001;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DRIVE,
      ST_SETTLE,
      ST_SAMPLE,
      ST_CLASSIFY,
      ST_DONE
   } state_t;

endpackage

// File: rtl/gate_tt_classifier.sv
// Maps a 4-entry truth table of a two-input gate to its gate identifier.
// Purely combinational so any gate-bank checker can reuse it.
module gate_tt_classifier
   import gate_pkg::*;
(
   input  logic [3:0] i_truth_tbl,
   output logic [2:0] o_gate_id,
   output logic       o_valid_gate
);

   // NOTE: every output gets a default before the case so no latch is inferred.
   always_comb begin
      o_gate_id = GATE_UNKNOWN;
      case (i_truth_tbl)
         TT_AND:  o_gate_id = GATE_AND;
         TT_OR:   o_gate_id = GATE_OR;
         TT_NAND: o_gate_id = GATE_NAND;
         TT_NOTB: o_gate_id = GATE_NOTB;
         TT_NOR:  o_gate_id = GATE_NOR;
         TT_XOR:  o_gate_id = GATE_XOR;
         TT_XNOR: o_gate_id = GATE_XNOR;
         default: o_gate_id = GATE_UNKNOWN;
      endcase
   end

   assign o_valid_gate = (o_gate_id != GATE_UNKNOWN);

endmodule

// File: rtl/gate_function_identifier.sv
// Sweeps {a,b} through 00,01,10,11 into an external gate, samples its response
// after a settle window and classifies the resulting truth table.
module gate_function_identifier
   import gate_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   input  logic       resp,
   output logic       drive_a,
   output logic       drive_b,
   output logic       busy,
   output logic       done,
   output logic [3:0] truth_tbl,
   output logic [2:0] gate_id,
   output logic       valid_gate
);

   localparam int unsigned CNT_W =
      ($clog2(SETTLE_CYCLES + 1) > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
   // SETTLE lasts SETTLE_CYCLES-1 cycles; counter runs 0..SETTLE_CYCLES-2.
   localparam int unsigned SETTLE_LAST = (SETTLE_CYCLES >= 2) ? SETTLE_CYCLES - 2 : 0;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [1:0]       r_idx;
   logic [1:0]       w_idx_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [3:0]       r_shadow;
   logic             w_sample;
   logic             w_load;
   logic             r_drive_a;
   logic             r_drive_b;
   logic             r_busy;
   logic             r_done;
   logic [3:0]       r_truth_tbl;
   logic [2:0]       r_gate_id;
   logic             r_valid_gate;
   logic [2:0]       w_gate_id;
   logic             w_valid_gate;
   logic             w_active_nxt;

   gate_tt_classifier u_classifier (
      .i_truth_tbl  (r_shadow),
      .o_gate_id    (w_gate_id),
      .o_valid_gate (w_valid_gate)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_cnt_nxt   = r_cnt;
      w_sample    = 1'b0;
      w_load      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start && !abort) begin
               w_state_nxt = ST_DRIVE;
               w_idx_nxt   = 2'd0;
            end
         end
         ST_DRIVE: begin
            w_cnt_nxt = '0;
            if (SETTLE_CYCLES == 0) begin
               // Zero settle: the drive cycle itself is the sample window.
               w_sample = 1'b1;
               if (r_idx == 2'd3) begin
                  w_state_nxt = ST_CLASSIFY;
               end else begin
                  w_state_nxt = ST_DRIVE;
                  w_idx_nxt   = r_idx + 2'd1;
               end
            end else if (SETTLE_CYCLES == 1) begin
               w_state_nxt = ST_SAMPLE;
            end else begin
               w_state_nxt = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (r_cnt == CNT_W'(SETTLE_LAST)) begin
               w_state_nxt = ST_SAMPLE;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         ST_SAMPLE: begin
            w_sample = 1'b1;
            if (r_idx == 2'd3) begin
               w_state_nxt = ST_CLASSIFY;
            end else begin
               w_state_nxt = ST_DRIVE;
               w_idx_nxt   = r_idx + 2'd1;
            end
         end
         ST_CLASSIFY: begin
            w_load      = 1'b1;
            w_state_nxt = ST_DONE;
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase

      // Abort overrides everything and leaves the published results untouched.
      if (abort && (r_state != ST_IDLE)) begin
         w_state_nxt = ST_IDLE;
         w_sample    = 1'b0;
         w_load      = 1'b0;
      end
   end

   assign w_active_nxt = (w_state_nxt == ST_DRIVE) || (w_state_nxt == ST_SETTLE) ||
                         (w_state_nxt == ST_SAMPLE);

   // NOTE: state is updated with non-blocking assignments so every register
   // sees the pre-edge values of the others.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_idx        <= 2'd0;
         r_cnt        <= '0;
         r_shadow     <= 4'b0000;
         r_drive_a    <= 1'b0;
         r_drive_b    <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_truth_tbl  <= 4'b0000;
         r_gate_id    <= GATE_UNKNOWN;
         r_valid_gate <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_sample) begin
            r_shadow[r_idx] <= resp;
         end
         // Drives take the new combo on the edge entering DRIVE so the gate
         // has the whole window to settle before the sampling edge.
         if (w_active_nxt) begin
            {r_drive_a, r_drive_b} <= w_idx_nxt;
         end else begin
            {r_drive_a, r_drive_b} <= 2'b00;
         end
         r_busy <= w_active_nxt || (w_state_nxt == ST_CLASSIFY);
         r_done <= (w_state_nxt == ST_DONE);
         if (w_load) begin
            r_truth_tbl  <= r_shadow;
            r_gate_id    <= w_gate_id;
            r_valid_gate <= w_valid_gate;
         end
      end
   end

   assign drive_a    = r_drive_a;
   assign drive_b    = r_drive_b;
   assign busy       = r_busy;
   assign done       = r_done;
   assign truth_tbl  = r_truth_tbl;
   assign gate_id    = r_gate_id;
   assign valid_gate = r_valid_gate;

endmodule

// File: tb/tb_gate_function_identifier.sv
// Directed bench: behavioural gate models on resp for SETTLE_CYCLES=2 and 0,
// checking drive order, done latency, classification, abort, re-start and reset.
module tb_gate_function_identifier;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;

   logic       start2 = 1'b0, abort2 = 1'b0, resp2;
   logic       drive_a2, drive_b2, busy2, done2, valid2;
   logic [3:0] tt2;
   logic [2:0] id2;
   logic [3:0] model_tt2 = 4'b0000;
   logic       glitch2 = 1'b0;

   logic       start0 = 1'b0, abort0 = 1'b0, resp0;
   logic       drive_a0, drive_b0, busy0, done0, valid0;
   logic [3:0] tt0;
   logic [2:0] id0;
   logic [3:0] model_tt0 = 4'b0000;

   int         n_checks = 0;
   int         n_fail = 0;
   int         done_cyc;
   int         done_cnt;
   logic [1:0] drv_log [0:31];

   always #5 clk = ~clk;

   // Behavioural gates: output is the table entry for the current drives.
   always_comb resp2 = model_tt2[{drive_a2, drive_b2}] ^ glitch2;
   always_comb resp0 = model_tt0[{drive_a0, drive_b0}];

   gate_function_identifier #(.SETTLE_CYCLES(2)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2), .resp(resp2),
      .drive_a(drive_a2), .drive_b(drive_b2), .busy(busy2), .done(done2),
      .truth_tbl(tt2), .gate_id(id2), .valid_gate(valid2)
   );

   gate_function_identifier #(.SETTLE_CYCLES(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .resp(resp0),
      .drive_a(drive_a0), .drive_b(drive_b0), .busy(busy0), .done(done0),
      .truth_tbl(tt0), .gate_id(id0), .valid_gate(valid0)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One sweep; cycle c is the c-th cycle after the accepting edge, sampled at negedge.
   task automatic sweep(input logic [3:0] tt, input bit sel, input int abort_at,
                        input bit repulse, input bit glitchy);
      int n_cyc;
      n_cyc    = sel ? 12 : 24;
      done_cyc = 0;
      done_cnt = 0;
      @(negedge clk);
      if (sel) begin model_tt0 = tt; start0 = 1'b1; end
      else     begin model_tt2 = tt; start2 = 1'b1; end
      @(posedge clk);
      for (int c = 1; c <= n_cyc; c++) begin
         @(negedge clk);
         start0  = 1'b0;
         start2  = repulse && !sel && (c == 5 || c == 14);
         abort2  = (abort_at != 0) && (c == abort_at);
         glitch2 = glitchy && (c % 3 == 1);
         drv_log[c] = sel ? {drive_a0, drive_b0} : {drive_a2, drive_b2};
         if ((sel ? done0 : done2) === 1'b1) begin
            done_cnt++;
            if (done_cyc == 0) done_cyc = c;
         end
         if (c == 1 && abort_at == 0) check("busy_after_accept", sel ? busy0 : busy2, 1);
         if (abort_at != 0 && c == abort_at + 1) begin
            check("abort_busy_low", busy2, 0);
            check("abort_drive_00", {drive_a2, drive_b2}, 2'b00);
         end
      end
      start2  = 1'b0;
      abort2  = 1'b0;
      glitch2 = 1'b0;
   endtask

   task automatic check_result(input string tag, input logic [3:0] e_tt,
                               input logic [2:0] e_id, input logic e_valid);
      check({tag, "_done_cycle"}, done_cyc, 14);
      check({tag, "_done_pulses"}, done_cnt, 1);
      check({tag, "_truth_tbl"}, tt2, e_tt);
      check({tag, "_gate_id"}, id2, e_id);
      check({tag, "_valid"}, valid2, e_valid);
   endtask

   logic [3:0] loop_tt [0:5];
   logic [2:0] loop_id [0:5];

   initial begin
      loop_tt = '{4'b1110, 4'b0111, 4'b0101, 4'b0001, 4'b0110, 4'b1001};
      loop_id = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};

      #1 rst_n = 1'b0;
      #1;
      check("rst_drive", {drive_a2, drive_b2}, 2'b00);
      check("rst_busy", busy2, 0);
      check("rst_done", done2, 0);
      check("rst_truth_tbl", tt2, 4'b0000);
      check("rst_gate_id", id2, 3'd7);
      check("rst_valid", valid2, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // AND gate: drives 00,01,10,11 at the start of each 3-cycle window.
      sweep(4'b1000, 1'b0, 0, 1'b0, 1'b0);
      check("and_drive_c1", drv_log[1], 2'b00);
      check("and_drive_c4", drv_log[4], 2'b01);
      check("and_drive_c7", drv_log[7], 2'b10);
      check("and_drive_c10", drv_log[10], 2'b11);
      check("and_drive_c13", drv_log[13], 2'b00);
      check_result("and", 4'b1000, 3'd0, 1'b1);
      check("and_busy_in_done", busy2, 0);

      // resp stuck high is not a recognised gate.
      sweep(4'b1111, 1'b0, 0, 1'b0, 1'b0);
      check_result("tied1", 4'b1111, 3'd7, 1'b0);

      // Remaining gates, resp glitching during drive cycles for robustness.
      for (int g = 0; g < 6; g++) begin
         sweep(loop_tt[g], 1'b0, 0, 1'b0, 1'b1);
         check_result($sformatf("gate%0d", g + 1), loop_tt[g], loop_id[g], 1'b1);
      end

      // AND sweep aborted during combo 2 (cycles 7..9); XNOR result must survive.
      sweep(4'b1000, 1'b0, 8, 1'b0, 1'b0);
      check("abort_no_done", done_cnt, 0);
      check("abort_truth_tbl", tt2, 4'b1001);
      check("abort_gate_id", id2, 3'd6);
      check("abort_valid", valid2, 1);

      // start pulsed while busy and in the DONE cycle: ignored.
      sweep(4'b1110, 1'b0, 0, 1'b1, 1'b0);
      check_result("repulse", 4'b1110, 3'd1, 1'b1);
      check("repulse_idle_busy", busy2, 0);

      // Reset in the middle of a sweep.
      @(negedge clk);
      model_tt2 = 4'b0110;
      start2 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start2 = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_drive", {drive_a2, drive_b2}, 2'b00);
      check("midrst_busy", busy2, 0);
      check("midrst_done", done2, 0);
      check("midrst_truth_tbl", tt2, 4'b0000);
      check("midrst_gate_id", id2, 3'd7);
      check("midrst_valid", valid2, 0);
      @(negedge clk);
      check("midrst_hold_done", done2, 0);
      rst_n = 1'b1;
      sweep(4'b0110, 1'b0, 0, 1'b0, 1'b0);
      check_result("xor_after_rst", 4'b0110, 3'd5, 1'b1);

      // SETTLE_CYCLES=0 instance: one-cycle windows, done in cycle 6.
      sweep(4'b1111, 1'b1, 0, 1'b0, 1'b0);
      check("s0_drive_c1", drv_log[1], 2'b00);
      check("s0_drive_c2", drv_log[2], 2'b01);
      check("s0_drive_c4", drv_log[4], 2'b11);
      check("s0_done_cycle", done_cyc, 6);
      check("s0_done_pulses", done_cnt, 1);
      check("s0_truth_tbl", tt0, 4'b1111);
      check("s0_gate_id", id0, 3'd7);
      check("s0_valid", valid0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
